io_input_debounce: RTL and testbench

//  Conditions the board's raw switch and button inputs for the Risc32 I/O read path.

---
 rtl/io_input_debounce.sv | 98 +++++++++
 tb/tb_io_input_debounce.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/io_input_debounce.sv
// Switch/button conditioning for the Risc32 I/O read path: 2-flop sync, tick-based
// debounce, sticky press flags with write-1-to-clear, and the offset 1/2/3 read mux.
module io_input_debounce #(
  parameter int TICK_DIV       = 100000,
  parameter int STABLE_SAMPLES = 4,
  parameter int NUM_SW         = 16,
  parameter int NUM_BTN        = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SW-1:0]   sw_raw,
  input  logic [NUM_BTN-1:0]  btn_raw,
  input  logic [31:0]         io_address,
  input  logic                io_write_en,
  input  logic [31:0]         io_write_value,
  input  logic                io_read_en,
  output logic [31:0]         io_read_value
);

  localparam int NIN   = NUM_SW + NUM_BTN;
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [NIN-1:0]                     sync1_q, sync1_d;
  logic [NIN-1:0]                     sync2_q, sync2_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [NIN-1:0][STABLE_SAMPLES-1:0] shr_q, shr_d;
  logic [NIN-1:0]                     db_q, db_d;
  logic [NUM_BTN-1:0]                 btn_press_q, btn_press_d;

  logic                tick;
  logic                w1c_hit;
  logic [NUM_BTN-1:0]  w1c_mask;
  logic [NUM_BTN-1:0]  btn_rise;
  logic [NUM_SW-1:0]   sw_db;
  logic [NUM_BTN-1:0]  btn_db;
  logic                unused_ok;

  assign unused_ok = ^{io_read_en, io_address[31:3], io_write_value};

  assign sw_db  = db_q[NUM_SW-1:0];
  assign btn_db = db_q[NIN-1:NUM_SW];

  always_comb begin
    sync1_d = {btn_raw, sw_raw};
    sync2_d = sync1_q;

    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    shr_d = shr_q;
    db_d  = db_q;
    if (tick) begin
      for (int i = 0; i < NIN; i++) begin
        shr_d[i] = {shr_q[i][STABLE_SAMPLES-2:0], sync2_q[i]};
        if (&shr_d[i]) begin
          db_d[i] = 1'b1;
        end else if (~|shr_d[i]) begin
          db_d[i] = 1'b0;
        end
      end
    end

    // Set is OR-ed in after the clear so a same-cycle press survives the W1C.
    w1c_hit     = io_write_en && (io_address[1:0] == 2'b11) && !io_address[2];
    w1c_mask    = w1c_hit ? io_write_value[NUM_BTN-1:0] : '0;
    btn_rise    = db_d[NIN-1:NUM_SW] & ~db_q[NIN-1:NUM_SW];
    btn_press_d = (btn_press_q & ~w1c_mask) | btn_rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      shr_q       <= '0;
      db_q        <= '0;
      btn_press_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      shr_q       <= shr_d;
      db_q        <= db_d;
      btn_press_q <= btn_press_d;
    end
  end

  always_comb begin
    io_read_value = '0;
    unique case (io_address[1:0])
      2'b01:   io_read_value[NUM_SW-1:0]  = sw_db;
      2'b10:   io_read_value[NUM_BTN-1:0] = btn_db;
      2'b11:   io_read_value[NUM_BTN-1:0] = btn_press_q;
      default: io_read_value = '0;
    endcase
  end

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce with a fast prescaler (TICK_DIV=4, 3 samples).
module tb_io_input_debounce;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_raw;
  logic [4:0]  btn_raw;
  logic [31:0] io_address;
  logic        io_write_en;
  logic [31:0] io_write_value;
  logic        io_read_en;
  logic [31:0] io_read_value;

  int checks = 0;
  int errors = 0;

  io_input_debounce #(
    .TICK_DIV(4), .STABLE_SAMPLES(3), .NUM_SW(16), .NUM_BTN(5)
  ) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .btn_raw(btn_raw),
    .io_address(io_address), .io_write_en(io_write_en),
    .io_write_value(io_write_value), .io_read_en(io_read_en),
    .io_read_value(io_read_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] val);
    io_address = addr;
    io_read_en = 1'b1;
    #1;
    val = io_read_value;
    io_read_en = 1'b0;
  endtask

  logic [31:0] v;
  logic [31:0] acc2, acc3;
  int          first;

  initial begin
    reset = 1'b1; sw_raw = 16'hA5A5; btn_raw = '0;
    io_address = '0; io_write_en = 1'b0; io_write_value = '0; io_read_en = 1'b0;

    // 1. reset, then switch debounce latency
    cyc(2);
    rd(32'h1, v); chk("rst_sw", v, 32'h0);
    rd(32'h2, v); chk("rst_btn", v, 32'h0);
    rd(32'h3, v); chk("rst_press", v, 32'h0);
    cyc(1);
    reset = 1'b0;
    rd(32'h1, v); chk("rel_sw", v, 32'h0);
    rd(32'h3, v); chk("rel_press", v, 32'h0);
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      rd(32'h1, v);
      if (first == 0 && v == 32'h0000A5A5) first = c;
    end
    chk("sw_latency_window", 32'((first >= 10) && (first <= 18)), 32'h1);
    rd(32'h1, v);          chk("sw_value", v, 32'h0000A5A5);
    rd(32'hFFFF_FFF1, v);  chk("sw_hi_addr_ignored", v, 32'h0000A5A5);
    rd(32'h0, v);          chk("off0_zero", v, 32'h0);

    // 2. short glitch on btn0 must never pass
    acc2 = '0; acc3 = '0;
    btn_raw[0] = 1'b1;
    for (int c = 0; c < 26; c++) begin
      if (c == 6) btn_raw[0] = 1'b0;
      cyc(1);
      rd(32'h2, v); acc2 |= v;
      rd(32'h3, v); acc3 |= v;
    end
    chk("glitch_db", acc2, 32'h0);
    chk("glitch_press", acc3, 32'h0);

    // 3. long press on btn2, then release
    btn_raw[2] = 1'b1;
    cyc(40);
    rd(32'h2, v); chk("b2_db", v, 32'h4);
    rd(32'h3, v); chk("b2_press", v, 32'h4);
    btn_raw[2] = 1'b0;
    cyc(30);
    rd(32'h2, v); chk("b2_rel_db", v, 32'h0);
    rd(32'h3, v); chk("b2_rel_press", v, 32'h4);

    // 4. W1C with btn_press = 5'h14
    btn_raw[4] = 1'b1;
    cyc(40);
    btn_raw[4] = 1'b0;
    cyc(30);
    rd(32'h3, v); chk("press_14", v, 32'h14);
    io_address = 32'h3; io_write_value = 32'h4; io_write_en = 1'b1;
    cyc(1);
    io_write_en = 1'b0;
    rd(32'h3, v); chk("w1c_bit2", v, 32'h10);
    io_address = 32'h7; io_write_value = 32'hFFFF_FFFF; io_write_en = 1'b1;
    cyc(1);
    io_write_en = 1'b0;
    rd(32'h3, v); chk("w1c_addr7_ignored", v, 32'h10);
    io_address = 32'h2; io_write_value = 32'hFFFF_FFFF; io_write_en = 1'b1;
    cyc(1);
    io_write_en = 1'b0;
    rd(32'h3, v); chk("w1c_addr2_ignored", v, 32'h10);

    // 5. W1C of bit1 held until the cycle btn_db[1] rises: set must win
    btn_raw[1] = 1'b1;
    io_address = 32'h3; io_write_value = 32'h2; io_write_en = 1'b1;
    first = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      cyc(1);
      if (io_read_value[1]) first = c;
    end
    io_write_en = 1'b0;
    chk("b1_rise_seen", 32'(first != 0), 32'h1);
    cyc(1);
    rd(32'h3, v); chk("set_wins", v, 32'h12);
    rd(32'h2, v); chk("b1_db", v, 32'h2);
    btn_raw[1] = 1'b0;
    cyc(30);

    // 6. reset while btn3 held with its flag pending
    btn_raw[3] = 1'b1;
    cyc(40);
    rd(32'h3, v); chk("b3_press_pre", v, 32'h1A);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    rd(32'h1, v); chk("mid_rst_sw", v, 32'h0);
    rd(32'h2, v); chk("mid_rst_btn", v, 32'h0);
    rd(32'h3, v); chk("mid_rst_press", v, 32'h0);
    first = 0;
    for (int c = 1; c <= 25 && first == 0; c++) begin
      cyc(1);
      rd(32'h3, v);
      if (v[3]) first = c;
    end
    chk("b3_repress_window", 32'((first >= 10) && (first <= 18)), 32'h1);
    rd(32'h3, v); chk("b3_repress", v, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
